// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine that owns the HI/LO register pair.
// It runs one shift-add or restoring-divide step per cycle, then applies sign correction in a final step.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic               is_div_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic [WIDTH-1:0]   mag_op_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;

    logic               is_div_s;
    logic               sa_s;
    logic               sb_s;
    logic               b_zero_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Operand conditioning: only signed ops (op[0]==0) take magnitudes.
    always_comb begin
        is_div_s = op[1];
        sa_s     = ~op[0] & a[WIDTH-1];
        sb_s     = ~op[0] & b[WIDTH-1];
        b_zero_s = (b == {WIDTH{1'b0}});
        if (sa_s) begin
            mag_a_s = -a;
        end else begin
            mag_a_s = a;
        end
        if (sb_s) begin
            mag_b_s = -b;
        end else begin
            mag_b_s = b;
        end
    end

    // One iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mag_op_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mag_op_r};
        if (div_diff_s[WIDTH]) begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction; remainder follows the dividend sign.
    always_comb begin
        if (neg_res_r) begin
            prod_s = -acc_r;
            quo_s  = -acc_r[WIDTH-1:0];
        end else begin
            prod_s = acc_r;
            quo_s  = acc_r[WIDTH-1:0];
        end
        if (neg_rem_r) begin
            rem_s = -acc_r[2*WIDTH-1:WIDTH];
        end else begin
            rem_s = acc_r[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM, datapath registers and HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            mag_op_r   <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (is_div_s && b_zero_s) begin
                            done_r     <= 1'b1;
                            div_zero_r <= 1'b1;
                        end else begin
                            state_r    <= RUN;
                            busy_r     <= 1'b1;
                            div_zero_r <= 1'b0;
                            cnt_r      <= {CW{1'b0}};
                            is_div_r   <= is_div_s;
                            neg_res_r  <= sa_s ^ sb_s;
                            neg_rem_r  <= sa_s;
                            mag_op_r   <= is_div_s ? mag_b_s : mag_a_s;
                            acc_r      <= {{WIDTH{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
                        end
                    end else begin
                        if (hi_we) begin
                            hi_r <= wdata;
                        end
                        if (lo_we) begin
                            lo_r <= wdata;
                        end
                    end
                end
                RUN: begin
                    acc_r <= is_div_r ? div_next_s : mul_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_r) begin
                        hi_r <= rem_s;
                        lo_r <= quo_s;
                    end else begin
                        hi_r <= prod_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_s[WIDTH-1:0];
                    end
                    cnt_r   <= {CW{1'b0}};
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: WIDTH=32 and WIDTH=8 instances, directed vectors.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, hi_we32, lo_we32, busy32, done32, dz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, wdata32, hi32, lo32;
    logic        start8, hi_we8, lo_we8, busy8, done8, dz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wdata8, hi8, lo8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ndone32 = 0;
    exp_t q32[$];
    exp_t q8[$];

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor for the 32-bit unit: every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            ndone32++;
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done32 actual=1 expected=0");
            end else begin
                e = q32.pop_front();
                chk("hi32", hi32, e.hi);
                chk("lo32", lo32, e.lo);
                chk("div_zero32", dz32, e.dz);
                chk("busy_at_done32", busy32, 1'b0);
                chk("latency32", cyc - e.t0 - 1, e.lat);
            end
        end
    end

    // Monitor for the 8-bit unit.
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done8 actual=1 expected=0");
            end else begin
                e = q8.pop_front();
                chk("hi8", hi8, e.hi);
                chk("lo8", lo8, e.lo);
                chk("div_zero8", dz8, e.dz);
                chk("busy_at_done8", busy8, 1'b0);
                chk("latency8", cyc - e.t0 - 1, e.lat);
            end
        end
    end

    // Called at a negedge; start is held across exactly one rising edge.
    task automatic issue32(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                           input logic [31:0] eh, input logic [31:0] el, input logic edz,
                           input int lat, input bit push);
        start32 = 1'b1; op32 = o; a32 = aa; b32 = bb;
        if (push) q32.push_back('{hi: eh, lo: el, dz: edz, lat: lat, t0: cyc});
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          input logic [31:0] eh, input logic [31:0] el, input int lat);
        start8 = 1'b1; op8 = o; a8 = aa; b8 = bb;
        q8.push_back('{hi: eh, lo: el, dz: 1'b0, lat: lat, t0: cyc});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q32.size() != 0 || q8.size() != 0) begin
            failures++;
            $display("FAIL timeout_%s actual=%0d expected=0", name, q32.size() + q8.size());
            q32.delete();
            q8.delete();
        end
    endtask

    initial begin
        int n;
        int snap;
        reset = 1'b1;
        start32 = 1'b0; op32 = 2'd0; a32 = 32'd0; b32 = 32'd0;
        hi_we32 = 1'b0; lo_we32 = 1'b0; wdata32 = 32'd0;
        start8 = 1'b0; op8 = 2'd0; a8 = 8'd0; b8 = 8'd0;
        hi_we8 = 1'b0; lo_we8 = 1'b0; wdata8 = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_hi", hi32, 32'd0);
        chk("reset_lo", lo32, 32'd0);
        chk("reset_busy", busy32, 1'b0);
        chk("reset_done", done32, 1'b0);
        chk("reset_dz", dz32, 1'b0);

        issue32(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b1);
        chk("busy_after_start", busy32, 1'b1);
        drain("mult");

        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b1);
        drain("multu");
        issue32(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1);
        repeat (10) @(negedge clk);
        chk("lo_stable_in_run", lo32, 32'h00000001);
        chk("hi_stable_in_run", hi32, 32'hFFFFFFFE);
        drain("divu");

        issue32(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b1);
        drain("div_neg");
        issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, 1'b1);
        drain("div_ovf");

        hi_we32 = 1'b1; wdata32 = 32'h1234;
        @(negedge clk);
        hi_we32 = 1'b0; lo_we32 = 1'b1; wdata32 = 32'h5678;
        @(negedge clk);
        lo_we32 = 1'b0;
        chk("mthi", hi32, 32'h1234);
        chk("mtlo", lo32, 32'h5678);
        issue32(2'b10, 32'd5, 32'd0, 32'h1234, 32'h5678, 1'b1, 0, 1'b1);
        chk("busy_div_zero", busy32, 1'b0);
        drain("div_zero");
        repeat (3) @(negedge clk);
        chk("dz_hold", dz32, 1'b1);
        issue32(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 1'b1);
        chk("dz_cleared", dz32, 1'b0);
        drain("after_dz");

        // Mid-run start and MTHI must both be ignored.
        issue32(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 33, 1'b1);
        repeat (4) @(negedge clk);
        start32 = 1'b1; a32 = 32'd100; b32 = 32'd100;
        @(negedge clk);
        start32 = 1'b0; hi_we32 = 1'b1; wdata32 = 32'hDEADBEEF;
        @(negedge clk);
        hi_we32 = 1'b0;
        drain("ignored");

        issue32(2'b01, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_hi", hi32, 32'd0);
        chk("rst_mid_lo", lo32, 32'd0);
        chk("rst_mid_busy", busy32, 1'b0);
        snap = ndone32;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", ndone32, snap);

        // Back-to-back: new start raised in the done cycle.
        issue32(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, 1'b1);
        n = 0;
        while (!done32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        issue32(2'b11, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 33, 1'b1);
        drain("back_to_back");

        issue8(2'b00, 8'h80, 8'h80, 32'h40, 32'h00, 9);
        drain("mult8");
        issue8(2'b10, 8'h81, 8'h03, 32'hFF, 32'hD6, 9);
        drain("div8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
